ycr1_mem_router_rr: RTL
=======================

Name: ycr1_mem_router_rr

Overview:
- N-master to 1-slave memory request router with round-robin arbitration.
- Supports up to OUTSTD pipelined outstanding requests and returns each response to the master that issued it, in order.
- Sits between core/DMA memory ports and the icache/dcache slave port.
- Uses the core mem-interface handshake:
  - req/req_ack/cmd/width/addr/wdata on the request side.
  - rdata/resp on the response side.
  - resp codes: 2'b00 NOTRDY, 2'b01 RDY_OK, 2'b10 RDY_ER.

Parameters:
- N_MST, 2, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- OUTSTD, 2, outstanding-request depth, i.e. ID FIFO depth (1..8).
- IDW, $clog2(N_MST) (min 1), derived master-index width; not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mst_req  in  N_MST  per-master request; held until acked.
- mst_cmd  in  N_MST  per-master command (0 read, 1 write).
- mst_width  in  2*N_MST  per-master access width, packed, master i at [2i+1:2i].
- mst_addr  in  AW*N_MST  per-master address, packed.
- mst_wdata  in  DW*N_MST  per-master write data, packed.
- mst_req_ack  out  N_MST  per-master request accept.
- mst_rdata  out  DW*N_MST  per-master read data, packed.
- mst_resp  out  2*N_MST  per-master response code, packed.
- slv_req  out  1  request to slave.
- slv_cmd  out  1  command to slave.
- slv_width  out  2  width to slave.
- slv_addr  out  AW  address to slave.
- slv_wdata  out  DW  write data to slave.
- slv_req_ack  in  1  slave accepts request.
- slv_rdata  in  DW  slave read data.
- slv_resp  in  2  slave response code.
- orphan_err  out  1  sticky flag: a response arrived with no outstanding request.

Behaviour:
- Reset (async on rst_n low) clears all state:
  - RR pointer = 0, lock = 0, ID FIFO empty (count 0), orphan_err = 0.
  - All outputs 0 while reset is asserted; reset mid-transaction discards outstanding IDs.
- Arbitration:
  - When not locked, the winner is the first requesting master scanning from RR pointer upward, modulo N_MST.
  - After master k is accepted, RR pointer = (k+1) mod N_MST.
- Lock:
  - If slv_req is high and slv_req_ack is low, the current winner is registered and lock is set.
  - While locked, the selected master does not change; lock clears on the accept cycle.
  - No regrant mid-request.
- Request path (combinational mux of the winner):
  - slv_req = winner's req AND (count < OUTSTD).
  - With no requester or a full FIFO, slv_req = 0 and the other slv_* outputs = 0.
- Accept:
  - Occurs when slv_req && slv_req_ack. mst_req_ack[winner] = 1 in the same cycle; all other mst_req_ack = 0.
  - The winner index is pushed into the ID FIFO; count increments at the next edge.
  - Zero added latency on the request path.
- Response:
  - Any cycle with slv_resp != NOTRDY and count > 0 pops the FIFO head h.
  - mst_resp[h] = slv_resp and mst_rdata[h] = slv_rdata in the same cycle (combinational).
  - All other masters see resp = NOTRDY and rdata = 0.
  - In-order responses only.
- Simultaneous push and pop: count unchanged, pointers both advance.
- Full: the accept decision uses registered count. When count == OUTSTD, no accept occurs even if a pop happens in the same cycle; the request waits one cycle.
- Orphan response (slv_resp != NOTRDY while count == 0):
  - Response dropped, all mst_resp = NOTRDY.
  - orphan_err set; it stays set until reset.
- FIFO pointers wrap modulo OUTSTD; count is width $clog2(OUTSTD+1).
- RDY_ER is routed identically to RDY_OK and still pops the FIFO.
- Per-master mst_req_ack/mst_resp are never asserted to more than one master in the same cycle.

Test Plan:
- Single master read: mst_req[0]=1, addr 0x100, slave acks at cycle 0 and responds RDY_OK with rdata 0xDEADBEEF at cycle 2 -> mst_req_ack[0] at cycle 0, mst_resp[0]=01 and mst_rdata[0]=0xDEADBEEF at cycle 2, master 1 sees 00/0.
- Fairness with N_MST=3: all three request continuously, slave always acks and responds next cycle -> accept order 0,1,2,0,1,2 and each response routed to the matching master.
- Outstanding limit with OUTSTD=2: slave acks every cycle but withholds responses -> two accepts, then slv_req=0. First response pops one entry; the next accept occurs one cycle after the pop.
- Lock: master 0 requests and slave holds ack low for 3 cycles while master 1 asserts req -> slv_addr stays on master 0 for all 3 cycles. Master 0 is accepted, then master 1 is accepted next.
- Error and orphan: slave returns RDY_ER for master 1's request -> mst_resp[1]=10 and count decrements. Then RDY_OK with count 0 -> orphan_err=1, no mst_resp asserted.
- Reset mid-operation: rst_n low with count 2 and lock set -> all outputs 0 immediately. After release, the first request from master 1 is accepted with no stale responses routed.

Source files
------------

// File: rtl/ycr1_mem_router_rr.sv
`default_nettype none
// ============================================================================
// Module   : ycr1_mem_router_rr
// Brief    : N-master to 1-slave round-robin memory router, in-order responses.
// Revision : 1.0
// ============================================================================
module ycr1_mem_router_rr #(
   parameter int N_MST  = 2,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int OUTSTD = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_MST-1:0]      mst_req,
   input  logic [N_MST-1:0]      mst_cmd,
   input  logic [2*N_MST-1:0]    mst_width,
   input  logic [AW*N_MST-1:0]   mst_addr,
   input  logic [DW*N_MST-1:0]   mst_wdata,
   output logic [N_MST-1:0]      mst_req_ack,
   output logic [DW*N_MST-1:0]   mst_rdata,
   output logic [2*N_MST-1:0]    mst_resp,
   output logic                  slv_req,
   output logic                  slv_cmd,
   output logic [1:0]            slv_width,
   output logic [AW-1:0]         slv_addr,
   output logic [DW-1:0]         slv_wdata,
   input  logic                  slv_req_ack,
   input  logic [DW-1:0]         slv_rdata,
   input  logic [1:0]            slv_resp,
   output logic                  orphan_err
);

   localparam int IDW = (N_MST > 1) ? $clog2(N_MST) : 1;
   localparam int CW  = $clog2(OUTSTD + 1);
   localparam int PW  = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;
   localparam logic [1:0] c_resp_notrdy = 2'b00;

   logic [IDW-1:0] rr_q,       rr_d;
   logic           lock_q,     lock_d;
   logic [IDW-1:0] lock_idx_q, lock_idx_d;
   logic [CW-1:0]  cnt_q,      cnt_d;
   logic [PW-1:0]  wptr_q,     wptr_d;
   logic [PW-1:0]  rptr_q,     rptr_d;
   logic           orphan_q,   orphan_d;
   logic [IDW-1:0] fifo_q [OUTSTD];

   logic [IDW-1:0] w_win;
   logic           w_win_vld;
   logic           w_room;
   logic           w_acc;
   logic           w_resp_vld;
   logic           w_pop;
   logic [IDW-1:0] w_head;
   logic [1:0]     w_width_arr [N_MST];
   logic [AW-1:0]  w_addr_arr  [N_MST];
   logic [DW-1:0]  w_wdata_arr [N_MST];

   function automatic logic [IDW-1:0] f_rr_idx(input logic [IDW-1:0] base, input int off);
      int j;
      j = int'(base) + off;
      if (j >= N_MST) j = j - N_MST;
      return IDW'(j);
   endfunction

   function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(OUTSTD - 1)) ? '0 : p + PW'(1);
   endfunction

   // Descending scan so the closest requester above the pointer is assigned last.
   always_comb begin
      w_win     = rr_q;
      w_win_vld = 1'b0;
      if (lock_q) begin
         w_win     = lock_idx_q;
         w_win_vld = mst_req[lock_idx_q];
      end else begin
         for (int k = N_MST - 1; k >= 0; k--) begin
            if (mst_req[f_rr_idx(rr_q, k)]) begin
               w_win     = f_rr_idx(rr_q, k);
               w_win_vld = 1'b1;
            end
         end
      end
   end

   // Accept decision uses the registered count, so a same-cycle pop cannot free a slot.
   assign w_room     = (cnt_q < CW'(OUTSTD));
   assign slv_req    = rst_n & w_win_vld & w_room;
   assign slv_cmd    = slv_req & mst_cmd[w_win];
   assign slv_width  = slv_req ? w_width_arr[w_win] : 2'b00;
   assign slv_addr   = slv_req ? w_addr_arr[w_win]  : '0;
   assign slv_wdata  = slv_req ? w_wdata_arr[w_win] : '0;
   assign w_acc      = slv_req & slv_req_ack;
   assign w_resp_vld = (slv_resp != c_resp_notrdy);
   assign w_pop      = w_resp_vld && (cnt_q != '0);
   assign w_head     = fifo_q[rptr_q];
   assign orphan_err = orphan_q;

   generate
      for (genvar i = 0; i < N_MST; i++) begin : g_mst
         assign w_width_arr[i]         = mst_width[2*i +: 2];
         assign w_addr_arr[i]          = mst_addr[AW*i +: AW];
         assign w_wdata_arr[i]         = mst_wdata[DW*i +: DW];
         assign mst_req_ack[i]         = w_acc & (w_win == IDW'(i));
         assign mst_resp[2*i +: 2]     = (w_pop && (w_head == IDW'(i))) ? slv_resp  : c_resp_notrdy;
         assign mst_rdata[DW*i +: DW]  = (w_pop && (w_head == IDW'(i))) ? slv_rdata : '0;
      end
   endgenerate

   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      cnt_d      = cnt_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      orphan_d   = orphan_q | (w_resp_vld && (cnt_q == '0));
      if (w_acc) begin
         rr_d   = (w_win == IDW'(N_MST - 1)) ? '0 : w_win + IDW'(1);
         lock_d = 1'b0;
         wptr_d = f_ptr_inc(wptr_q);
      end else if (slv_req) begin
         lock_d     = 1'b1;
         lock_idx_d = w_win;
      end
      if (w_pop) begin
         rptr_d = f_ptr_inc(rptr_q);
      end
      if (w_acc && !w_pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!w_acc && w_pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         cnt_q      <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         orphan_q   <= 1'b0;
         for (int e = 0; e < OUTSTD; e++) begin
            fifo_q[e] <= '0;
         end
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         cnt_q      <= cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         orphan_q   <= orphan_d;
         if (w_acc) begin
            fifo_q[wptr_q] <= w_win;
         end
      end
   end

endmodule
`default_nettype wire
